// File: rtl/accel_load_ctrl_pkg.sv
// Shared types for the accelerator load controller.
// State encoding and memory-select codes.
package accel_load_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_COMMIT,
      S_WAIT_RDY,
      S_START,
      S_DONE
   } state_e;

   localparam logic [2:0] SEL_X    = 3'd6;
   localparam logic [2:0] SEL_RSVD = 3'd7;

   function automatic logic cmd_reject(
      input logic [2:0] sel,
      input logic       words_zero,
      input logic       rows_zero
   );
      return (sel == SEL_RSVD) || words_zero ||
             ((sel < SEL_X) && rows_zero);
   endfunction

endpackage

// File: rtl/accel_load_ctrl_if.sv
// Command, element stream and accelerator load-port bundle.
// master drives commands/data, slave is the controller.
interface accel_load_ctrl_if #(
   parameter int DATA_WIDTH    = 4,
   parameter int COUNTER_WIDTH = 16,
   parameter int ADDR_W        = 16,
   parameter int WORD_ADDR_W   = 10
);

   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [2:0]               cmd_sel;
   logic [ADDR_W-1:0]        cmd_base;
   logic [COUNTER_WIDTH-1:0] cmd_rows;
   logic [WORD_ADDR_W-1:0]   cmd_words;

   logic                     s_valid;
   logic                     s_ready;
   logic [DATA_WIDTH-1:0]    s_data;

   logic [DATA_WIDTH-1:0]    data_in;
   logic [WORD_ADDR_W-1:0]   wrd_addr;
   logic [2:0]               mem_sel;
   logic [ADDR_W-1:0]        mem_addr;
   logic                     mem_en;
   logic                     mem_wr;
   logic                     start;
   logic                     input_rdy;

   logic                     busy;
   logic                     done;
   logic                     err;

   modport master (
      output cmd_valid, cmd_sel, cmd_base, cmd_rows,
      output cmd_words, s_valid, s_data, input_rdy,
      input  cmd_ready, s_ready, data_in, wrd_addr,
      input  mem_sel, mem_addr, mem_en, mem_wr, start,
      input  busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_sel, cmd_base, cmd_rows,
      input  cmd_words, s_valid, s_data, input_rdy,
      output cmd_ready, s_ready, data_in, wrd_addr,
      output mem_sel, mem_addr, mem_en, mem_wr, start,
      output busy, done, err
   );

endinterface

// File: rtl/accel_load_ctrl.sv
// Streams elements into the accelerator word stack and commits
// rows to weight memories, or loads X and fires start.
module accel_load_ctrl
   import accel_load_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 4,
   parameter int COUNTER_WIDTH = 16,
   parameter int ADDR_W        = 16,
   parameter int WORD_ADDR_W   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   accel_load_ctrl_if.slave bus
);

   localparam logic [WORD_ADDR_W-1:0] PARK = '1;

   state_e state_q, state_d;

   logic [WORD_ADDR_W-1:0]   wcnt_q, wcnt_d;
   logic [WORD_ADDR_W-1:0]   words_q, words_d;
   logic [WORD_ADDR_W-1:0]   wrd_addr_q, wrd_addr_d;
   logic [COUNTER_WIDTH-1:0] rcnt_q, rcnt_d;
   logic [COUNTER_WIDTH-1:0] rows_q, rows_d;
   logic [ADDR_W-1:0]        base_q, base_d;
   logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
   logic [2:0]               mem_sel_q, mem_sel_d;
   logic [DATA_WIDTH-1:0]    data_in_q, data_in_d;
   logic                     mem_en_q, mem_en_d;
   logic                     start_q, start_d;
   logic                     err_q, err_d;

   logic last_word;
   logic last_row;
   logic reject;

   assign last_word = (wcnt_q == words_q - WORD_ADDR_W'(1));
   assign last_row  = (rcnt_q == rows_q - COUNTER_WIDTH'(1));
   assign reject    = cmd_reject(bus.cmd_sel,
                                 bus.cmd_words == '0,
                                 bus.cmd_rows == '0);

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      words_d    = words_q;
      rows_d     = rows_q;
      base_d     = base_q;
      mem_addr_d = mem_addr_q;
      mem_sel_d  = mem_sel_q;
      data_in_d  = data_in_q;
      wrd_addr_d = PARK;
      mem_en_d   = 1'b0;
      start_d    = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               words_d = bus.cmd_words;
               rows_d  = bus.cmd_rows;
               base_d  = bus.cmd_base;
               wcnt_d  = '0;
               rcnt_d  = '0;
               if (reject) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d   = S_FILL;
                  mem_sel_d = bus.cmd_sel;
               end
            end
         end
         S_FILL: begin
            if (bus.s_valid) begin
               data_in_d  = bus.s_data;
               wrd_addr_d = wcnt_q;
               wcnt_d     = wcnt_q + WORD_ADDR_W'(1);
               if (last_word) begin
                  if (mem_sel_q == SEL_X) begin
                     state_d = S_WAIT_RDY;
                  end else begin
                     state_d    = S_COMMIT;
                     mem_en_d   = 1'b1;
                     mem_addr_d = base_q + ADDR_W'(rcnt_q);
                  end
               end
            end
         end
         S_COMMIT: begin
            rcnt_d  = rcnt_q + COUNTER_WIDTH'(1);
            wcnt_d  = '0;
            state_d = last_row ? S_DONE : S_FILL;
         end
         S_WAIT_RDY: begin
            if (bus.input_rdy) begin
               state_d = S_START;
               start_d = 1'b1;
            end
         end
         S_START: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Target select is only meaningful while a command is live.
      if (state_d == S_DONE || state_d == S_IDLE) begin
         mem_sel_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         words_q    <= '0;
         rows_q     <= '0;
         base_q     <= '0;
         mem_addr_q <= '0;
         mem_sel_q  <= '0;
         data_in_q  <= '0;
         wrd_addr_q <= PARK;
         mem_en_q   <= 1'b0;
         start_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         words_q    <= words_d;
         rows_q     <= rows_d;
         base_q     <= base_d;
         mem_addr_q <= mem_addr_d;
         mem_sel_q  <= mem_sel_d;
         data_in_q  <= data_in_d;
         wrd_addr_q <= wrd_addr_d;
         mem_en_q   <= mem_en_d;
         start_q    <= start_d;
         err_q      <= err_d;
      end
   end

   assign bus.cmd_ready = rst_n && (state_q == S_IDLE);
   assign bus.s_ready   = (state_q == S_FILL);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;
   assign bus.data_in   = data_in_q;
   assign bus.wrd_addr  = wrd_addr_q;
   assign bus.mem_sel   = mem_sel_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_en_q;
   assign bus.start     = start_q;

endmodule

// File: tb/tb_accel_load_ctrl.sv
// Directed bench for accel_load_ctrl: weight rows, X load,
// stalls, rejected commands, mid-command reset, address wrap.
module tb_accel_load_ctrl;

   localparam int PARK = 1023;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   int n_en = 0, n_start = 0, n_done = 0, n_errp = 0, n_ovl = 0;
   int wq[$];
   int dq[$];
   int aq[$];
   int ex[$];

   accel_load_ctrl_if #(
      .DATA_WIDTH(4), .COUNTER_WIDTH(16),
      .ADDR_W(16), .WORD_ADDR_W(10)
   ) bus ();

   accel_load_ctrl #(
      .DATA_WIDTH(4), .COUNTER_WIDTH(16),
      .ADDR_W(16), .WORD_ADDR_W(10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.mem_en) begin
         n_en++;
         aq.push_back(int'(bus.mem_addr));
      end
      if (bus.start) n_start++;
      if (bus.done) n_done++;
      if (bus.err) n_errp++;
      if ((bus.mem_en && bus.start) || (bus.mem_en != bus.mem_wr))
         n_ovl++;
      if (int'(bus.wrd_addr) != PARK) begin
         wq.push_back(int'(bus.wrd_addr));
         dq.push_back(int'(bus.data_in));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_q(input string tag, input int got[$],
                        input int exp[$]);
      chk({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_%0d", tag, i), got[i], exp[i]);
   endtask

   task automatic tmo(input string tag);
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed timeout expected handshake", tag);
   endtask

   task automatic clr();
      n_en = 0; n_start = 0; n_done = 0; n_errp = 0;
      wq.delete(); dq.delete(); aq.delete();
   endtask

   task automatic issue(input logic [2:0] sel, input logic [15:0] base,
                        input logic [15:0] rows, input logic [9:0] words);
      int k = 0;
      bus.cmd_sel   = sel;
      bus.cmd_base  = base;
      bus.cmd_rows  = rows;
      bus.cmd_words = words;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) tmo("cmd_accept");
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] d);
      int k = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      while (!bus.s_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) tmo("s_accept");
      @(negedge clk);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!bus.done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) tmo("done_wait");
      @(negedge clk);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = '0;
      bus.cmd_base  = '0;
      bus.cmd_rows  = '0;
      bus.cmd_words = '0;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.input_rdy = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_wrd_addr", int'(bus.wrd_addr), PARK);
      chk("rst_data_in", int'(bus.data_in), 0);
      chk("rst_mem_sel", int'(bus.mem_sel), 0);
      chk("rst_mem_addr", int'(bus.mem_addr), 0);
      chk("rst_mem_en", int'(bus.mem_en), 0);
      chk("rst_start", int'(bus.start), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
      chk("rst_s_ready", int'(bus.s_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", int'(bus.cmd_ready), 1);

      // two weight rows, continuous stream
      clr();
      issue(3'd0, 16'd5, 16'd2, 10'd3);
      chk("w_busy", int'(bus.busy), 1);
      chk("w_s_ready", int'(bus.s_ready), 1);
      chk("w_cmd_ready", int'(bus.cmd_ready), 0);
      send(4'd1);
      send(4'd2);
      send(4'd3);
      chk("w_commit_en", int'(bus.mem_en), 1);
      chk("w_commit_wr", int'(bus.mem_wr), 1);
      chk("w_commit_addr", int'(bus.mem_addr), 5);
      chk("w_commit_sready", int'(bus.s_ready), 0);
      send(4'd4);
      chk("w_en_after_commit", int'(bus.mem_en), 0);
      send(4'd5);
      send(4'd6);
      chk("w_commit2_addr", int'(bus.mem_addr), 6);
      bus.s_valid = 1'b0;
      wait_done();
      repeat (2) @(negedge clk);
      ex = '{0, 1, 2, 0, 1, 2};
      chk_q("w_wrd", wq, ex);
      ex = '{1, 2, 3, 4, 5, 6};
      chk_q("w_data", dq, ex);
      ex = '{5, 6};
      chk_q("w_addr", aq, ex);
      chk("w_n_en", n_en, 2);
      chk("w_n_done", n_done, 1);
      chk("w_n_start", n_start, 0);
      chk("w_n_err", n_errp, 0);

      // X load, input_rdy low for 10 cycles
      clr();
      bus.input_rdy = 1'b0;
      issue(3'd6, 16'd0, 16'd0, 10'd4);
      chk("x_mem_sel", int'(bus.mem_sel), 6);
      send(4'd9);
      send(4'd10);
      send(4'd11);
      send(4'd12);
      bus.s_valid = 1'b0;
      chk("x_last_wrd", int'(bus.wrd_addr), 3);
      chk("x_no_en", int'(bus.mem_en), 0);
      repeat (10) @(negedge clk);
      chk("x_wait_start", int'(bus.start), 0);
      chk("x_wait_nstart", n_start, 0);
      chk("x_wait_busy", int'(bus.busy), 1);
      chk("x_wait_wrd", int'(bus.wrd_addr), PARK);
      bus.input_rdy = 1'b1;
      @(negedge clk);
      chk("x_start", int'(bus.start), 1);
      chk("x_start_done", int'(bus.done), 0);
      @(negedge clk);
      chk("x_done", int'(bus.done), 1);
      chk("x_done_start", int'(bus.start), 0);
      chk("x_done_sel", int'(bus.mem_sel), 0);
      bus.input_rdy = 1'b0;
      @(negedge clk);
      chk("x_idle_busy", int'(bus.busy), 0);
      ex = '{0, 1, 2, 3};
      chk_q("x_wrd", wq, ex);
      ex = '{9, 10, 11, 12};
      chk_q("x_data", dq, ex);
      chk("x_n_start", n_start, 1);
      chk("x_n_en", n_en, 0);
      chk("x_n_done", n_done, 1);

      // stalled stream
      clr();
      issue(3'd1, 16'h20, 16'd1, 10'd3);
      send(4'd7);
      chk("st_wrd0", int'(bus.wrd_addr), 0);
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("st_park0", int'(bus.wrd_addr), PARK);
      send(4'd8);
      chk("st_wrd1", int'(bus.wrd_addr), 1);
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("st_park1", int'(bus.wrd_addr), PARK);
      chk("st_sel", int'(bus.mem_sel), 1);
      send(4'd9);
      chk("st_wrd2", int'(bus.wrd_addr), 2);
      chk("st_en", int'(bus.mem_en), 1);
      chk("st_addr", int'(bus.mem_addr), 32);
      bus.s_valid = 1'b0;
      wait_done();
      ex = '{0, 1, 2};
      chk_q("st_wrd", wq, ex);
      chk("st_n_en", n_en, 1);

      // rejected commands
      for (int t = 0; t < 3; t++) begin
         clr();
         case (t)
            0: issue(3'd1, 16'd0, 16'd1, 10'd0);
            1: issue(3'd7, 16'd0, 16'd1, 10'd2);
            default: issue(3'd2, 16'd0, 16'd0, 10'd2);
         endcase
         chk($sformatf("rj%0d_err", t), int'(bus.err), 1);
         chk($sformatf("rj%0d_done", t), int'(bus.done), 1);
         chk($sformatf("rj%0d_sready", t), int'(bus.s_ready), 0);
         @(negedge clk);
         chk($sformatf("rj%0d_err_off", t), int'(bus.err), 0);
         chk($sformatf("rj%0d_idle", t), int'(bus.cmd_ready), 1);
         @(negedge clk);
         chk($sformatf("rj%0d_n_err", t), n_errp, 1);
         chk($sformatf("rj%0d_n_done", t), n_done, 1);
         chk($sformatf("rj%0d_n_en", t), n_en, 0);
         chk($sformatf("rj%0d_n_start", t), n_start, 0);
      end

      // reset mid-command
      clr();
      issue(3'd3, 16'd7, 16'd1, 10'd3);
      send(4'd1);
      send(4'd2);
      bus.s_valid = 1'b0;
      chk("mr_pre_wrd", int'(bus.wrd_addr), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_wrd", int'(bus.wrd_addr), PARK);
      chk("mr_data", int'(bus.data_in), 0);
      chk("mr_busy", int'(bus.busy), 0);
      chk("mr_sel", int'(bus.mem_sel), 0);
      chk("mr_addr", int'(bus.mem_addr), 0);
      chk("mr_sready", int'(bus.s_ready), 0);
      chk("mr_cready", int'(bus.cmd_ready), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_n_en", n_en, 0);
      chk("mr_cready_after", int'(bus.cmd_ready), 1);
      clr();
      issue(3'd0, 16'd9, 16'd1, 10'd3);
      send(4'd3);
      send(4'd4);
      send(4'd5);
      bus.s_valid = 1'b0;
      wait_done();
      ex = '{0, 1, 2};
      chk_q("mr2_wrd", wq, ex);
      ex = '{9};
      chk_q("mr2_addr", aq, ex);
      chk("mr2_n_done", n_done, 1);

      // address wrap
      clr();
      issue(3'd4, 16'hFFFF, 16'd2, 10'd1);
      send(4'd5);
      chk("wr_addr0", int'(bus.mem_addr), 16'hFFFF);
      send(4'd6);
      chk("wr_addr1", int'(bus.mem_addr), 0);
      bus.s_valid = 1'b0;
      wait_done();
      ex = '{16'hFFFF, 0};
      chk_q("wr_addr", aq, ex);
      chk("wr_n_en", n_en, 2);

      chk("no_overlap", n_ovl, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
